// File: rtl/g15_pkg.sv
`default_nettype none
// ============================================================================
// Module      : g15_pkg
// Description : Shared G-15 drum geometry, index types and reader FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package g15_pkg;

  localparam int WORD_BITS  = 29;
  localparam int LINE_WORDS = 108;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [6:0]           word_idx_t;
  typedef logic [4:0]           bit_idx_t;

  localparam bit_idx_t  LAST_BIT       = bit_idx_t'(WORD_BITS - 1);
  localparam word_idx_t LAST_WORD      = word_idx_t'(LINE_WORDS - 1);
  localparam word_idx_t WORDS_PER_LINE = word_idx_t'(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } rd_state_t;

  function automatic word_idx_t word_inc(input word_idx_t w);
    return (w == LAST_WORD) ? '0 : w + 7'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drum_timing_counter.sv
`default_nettype none
// ============================================================================
// Module      : drum_timing_counter
// Description : Bit/word position tracker driven by the drum timing marks.
// Revision    : 1.0 - initial release
// ============================================================================
module drum_timing_counter
  import g15_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_bit_sync,
  input  logic      i_line_sync,
  output bit_idx_t  o_bit_cnt,
  output bit_idx_t  o_bit_cnt_next,
  output word_idx_t o_next_word,
  output logic      o_synced
);

  bit_idx_t  r_bit_cnt;
  word_idx_t r_word_cnt;
  logic      r_synced;
  bit_idx_t  w_bit_cnt_next;
  word_idx_t w_next_word;

  always_comb begin
    w_bit_cnt_next = (i_bit_sync || r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 5'd1;
    w_next_word    = i_line_sync ? '0 : word_inc(r_word_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_synced   <= 1'b0;
    end else begin
      r_bit_cnt <= w_bit_cnt_next;
      if (i_bit_sync) begin
        r_word_cnt <= w_next_word;
        if (i_line_sync) r_synced <= 1'b1;
      end
    end
  end

  assign o_bit_cnt      = r_bit_cnt;
  assign o_bit_cnt_next = w_bit_cnt_next;
  assign o_next_word    = w_next_word;
  assign o_synced       = r_synced;

endmodule
`default_nettype wire

// File: rtl/drum_line_reader.sv
`default_nettype none
// ============================================================================
// Module      : drum_line_reader
// Description : Captures consecutive 29-bit words from a serial drum line and
//               hands them to the host over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module drum_line_reader
  import g15_pkg::*;
(
  input  logic        CLOCK,
  input  logic        rst_n,
  input  logic        BIT_SYNC,
  input  logic        LINE_SYNC,
  input  logic        SER_IN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_word,
  input  logic [6:0]  req_count,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [28:0] rd_data,
  output logic [6:0]  rd_index,
  output logic        busy,
  output logic        overrun,
  output logic        frame_err,
  output logic        req_err
);

  rd_state_t  r_state;
  rd_state_t  w_state_next;
  word_idx_t  r_target;
  word_idx_t  r_remain;
  word_idx_t  r_cap_index;
  logic [WORD_BITS-2:0] r_shreg;
  logic       r_rd_valid;
  word_t      r_rd_data;
  word_idx_t  r_rd_index;
  logic       r_overrun;
  logic       r_frame_err;
  logic       r_req_err;

  bit_idx_t   w_bit_cnt;
  bit_idx_t   w_bit_cnt_next;
  word_idx_t  w_next_word;
  logic       w_synced;
  logic       w_accept;
  logic       w_bad_req;
  logic       w_start;
  logic       w_misframe;
  logic       w_word_done;
  logic       w_rd_take;
  logic       w_load;
  word_idx_t  w_req_len;

  drum_timing_counter u_timing (
    .clk            (CLOCK),
    .rst_n          (rst_n),
    .i_bit_sync     (BIT_SYNC),
    .i_line_sync    (LINE_SYNC),
    .o_bit_cnt      (w_bit_cnt),
    .o_bit_cnt_next (w_bit_cnt_next),
    .o_next_word    (w_next_word),
    .o_synced       (w_synced)
  );

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_bad_req    = 1'b0;
    w_start      = 1'b0;
    w_misframe   = 1'b0;
    w_word_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (req_word > LAST_WORD) begin
            w_bad_req = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (BIT_SYNC && w_synced && w_next_word == r_target) begin
          w_start      = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        // A word boundary mark anywhere but after bit 28 means we lost framing.
        if (BIT_SYNC && w_bit_cnt != LAST_BIT) begin
          w_misframe = 1'b1;
        end else if (w_bit_cnt_next == LAST_BIT) begin
          w_word_done = 1'b1;
          if (r_remain == 7'd1) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_rd_take = r_rd_valid & rd_ready;
  assign w_load    = w_word_done & (~r_rd_valid | w_rd_take);
  assign w_req_len = (req_count == '0 || req_count > WORDS_PER_LINE) ? WORDS_PER_LINE : req_count;

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      r_target    <= '0;
      r_remain    <= '0;
      r_cap_index <= '0;
      r_shreg     <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_index  <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_req_err   <= 1'b0;
    end else begin
      // Bit 28 bypasses the shift register straight into the output word.
      if (w_bit_cnt_next != LAST_BIT) r_shreg[w_bit_cnt_next] <= SER_IN;
      r_req_err <= w_bad_req;

      if (w_accept) begin
        r_target    <= req_word;
        r_remain    <= w_req_len;
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end

      if (w_start) begin
        r_cap_index <= r_target;
      end else if (w_misframe) begin
        r_cap_index <= w_next_word;
        r_frame_err <= 1'b1;
      end else if (w_word_done) begin
        r_remain    <= r_remain - 7'd1;
        r_cap_index <= word_inc(r_cap_index);
        if (!w_load) r_overrun <= 1'b1;
      end

      if (w_load) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= {SER_IN, r_shreg};
        r_rd_index <= r_cap_index;
      end else if (w_rd_take) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_index  = r_rd_index;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign req_err   = r_req_err;

endmodule
`default_nettype wire

// File: doc/drum_line_reader.md
Name: drum_line_reader

Overview:
Bit-serial to word reader for G-15 drum lines. It tracks bit and word position from the drum timing marks and captures one or more consecutive 29-bit words from a selected serial read stream (an M or EB line, pre-muxed externally). It presents those words to a host-side consumer over a valid/ready handshake. It is the read-side counterpart of the line write path and serves the host/debug loader for inspecting lines 0–6.

Parameters:
WORD_BITS, 29, bits per drum word, LSB (sign/bit 0) first on the drum
LINE_WORDS, 108, words per line revolution (WORD_BITS*LINE_WORDS = 3132 bit times)

Ports:
CLOCK  in  1  bit-time clock, rising-edge
rst_n  in  1  asynchronous active-low reset
BIT_SYNC  in  1  high for the bit-0 clock of every word time
LINE_SYNC  in  1  high together with BIT_SYNC on bit 0 of word 0 only
SER_IN  in  1  serial drum data of the selected line
req_valid  in  1  host request strobe
req_ready  out  1  request accepted when req_valid & req_ready
req_word  in  7  first word index, 0..107
req_count  in  7  consecutive words to read; 0 means 108
rd_valid  out  1  captured word available
rd_ready  in  1  consumer takes word when rd_valid & rd_ready
rd_data  out  29  captured word, bit 0 = first bit on drum
rd_index  out  7  word index of rd_data
busy  out  1  request in progress (state != IDLE)
overrun  out  1  sticky: a captured word was dropped because output register was still full
frame_err  out  1  sticky: BIT_SYNC seen while bit counter != WORD_BITS-1 during capture
req_err  out  1  one-cycle pulse: request with req_word >= 108 rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1. bit_cnt=0, word_cnt=0, synced=0, rd_data=0, rd_index=0.
- Position tracking (every cycle, all states): BIT_SYNC -> bit_cnt=0, else bit_cnt+1 with wrap 28->0. LINE_SYNC&BIT_SYNC -> word_cnt=0, synced=1. BIT_SYNC alone -> word_cnt+1 with wrap 107->0. next_word = 0 if LINE_SYNC, else (word_cnt+1) mod 108.
- IDLE: req_ready=1. On accept: if req_word>=108, pulse req_err and stay IDLE. Otherwise latch target=req_word and remain=(req_count==0 ? 108 : min(req_count,108)), clear overrun and frame_err, and go to WAIT.
- WAIT: req_ready=0. On a cycle with BIT_SYNC & synced & next_word==target: shift SER_IN into shreg bit 0, set cap_index=target, go to SHIFT. Before the first LINE_SYNC after reset the block waits indefinitely.
- SHIFT: each cycle shreg[bit_cnt_next] = SER_IN. On the cycle that samples bit 28: remain--.
  - If output is free, or is being consumed in the same cycle (rd_valid & rd_ready): load rd_data and rd_index next edge and assert rd_valid.
  - Otherwise drop the word and set overrun. rd_data keeps the older word.
  - If remain reaches 0 -> IDLE. Else stay in SHIFT: the next BIT_SYNC starts word (cap_index+1) mod 108, wrapping 107->0.
- Latency: rd_valid rises on the clock after bit 28 is sampled. Full request = wait (0..107 word times) + 29*count bit times + 1.
- Misframe: BIT_SYNC during SHIFT with bit_cnt != 28. Set frame_err, discard the partial word, resynchronize with this cycle as bit 0 of next_word, and continue the count.
- rd_valid is cleared on rd_valid & rd_ready. It is independent of state, so the last word may be pending in IDLE. A new request may be accepted while rd_valid=1.
- rd_data and rd_index are stable while rd_valid & ~rd_ready.
- Sticky flags clear only on reset or on the next accepted request.

Decomposition:
- Shared package g15_pkg: WORD_BITS=29, LINE_WORDS=108, typedef word_t (logic[28:0]), typedef word_idx_t (logic[6:0]), enum rd_state_t {IDLE, WAIT, SHIFT}.
- One natural sub-module: drum_timing_counter. It holds bit_cnt, word_cnt, synced and next_word, and is reusable by a future drum_line_writer.
- FSM, shift register and output register stay in the top module.

Test Plan:
- Single word: after sync, request word 5, count 1. Drive word 5 = 29'h0ABCDEF LSB-first -> rd_valid one clock after its bit 28, rd_data=29'h0ABCDEF, rd_index=5, busy low the same cycle.
- Wrap: request word 106, count 4, rd_ready=1 -> four words with rd_index 106,107,0,1 and data matching drum content; overrun=0.
- Backpressure: request word 10, count 3, rd_ready=0 throughout -> rd_data holds word 10, overrun=1 after word 11 ends; raise rd_ready -> one transfer with index 10, then rd_valid=0.
- Pre-sync and error: request before any LINE_SYNC -> busy stays 1 with no capture until LINE_SYNC, then capture. Request req_word=108 -> req_err pulse, busy=0.
- Misframe: inject early BIT_SYNC at bit_cnt=12 mid-capture -> frame_err=1, partial word discarded, next word captured with the correct index.
- Reset mid-SHIFT: assert rst_n=0 asynchronously -> rd_valid, busy and flags are 0 immediately and req_ready=1. After release, a new request works once LINE_SYNC reappears.
